// File: rtl/av_rr_arbiter_pkg.sv
// Shared types and limits for the round-robin Avalon-MM arbiter.
package av_arb_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    CMD    = 2'd1,
    RDWAIT = 2'd2,
    DONE   = 2'd3
  } arb_state_e;

  localparam int MST_NUM_MIN = 2;
  localparam int MST_NUM_MAX = 8;
  localparam int RD_LAT_MIN  = 1;
  localparam int RD_LAT_MAX  = 4;

  // Index and latency counters are sized for the largest legal configuration.
  localparam int IDX_W = $clog2(MST_NUM_MAX);
  localparam int CNT_W = $clog2(RD_LAT_MAX);

  function automatic logic [IDX_W-1:0] wrap_inc(input logic [IDX_W-1:0] idx,
                                                input int unsigned     n);
    if (idx == IDX_W'(n - 1)) begin
      return '0;
    end else begin
      return idx + IDX_W'(1);
    end
  endfunction

endpackage

// File: rtl/av_rr_arbiter_if.sv
// Master-side and slave-side Avalon-MM signals seen by the arbiter.
interface av_rr_arbiter_if #(
  parameter int DW      = 32,
  parameter int AW      = 16,
  parameter int MST_NUM = 2
);
  localparam int BW = DW / 8;

  logic [MST_NUM-1:0][AW-1:0] m_address;
  logic [MST_NUM-1:0][BW-1:0] m_byteenable;
  logic [MST_NUM-1:0]         m_read;
  logic [MST_NUM-1:0]         m_write;
  logic [MST_NUM-1:0][DW-1:0] m_writedata;
  logic [MST_NUM-1:0]         m_waitrequest;
  logic [DW-1:0]              m_readdata;

  logic [AW-1:0]              avms_address;
  logic [BW-1:0]              avms_byteenable;
  logic                       avms_read;
  logic                       avms_write;
  logic [DW-1:0]              avms_writedata;
  logic [DW-1:0]              avms_readdata;

  // The arbiter masters the shared slave port.
  modport master (
    input  m_address, m_byteenable, m_read, m_write, m_writedata, avms_readdata,
    output m_waitrequest, m_readdata,
    output avms_address, avms_byteenable, avms_read, avms_write, avms_writedata
  );

  modport slave (
    output m_address, m_byteenable, m_read, m_write, m_writedata, avms_readdata,
    input  m_waitrequest, m_readdata,
    input  avms_address, avms_byteenable, avms_read, avms_write, avms_writedata
  );

endinterface

// File: rtl/av_rr_arbiter_rr_grant.sv
// Round-robin search starting at ptr_i with wrap; produces one-hot grant and index.
module rr_grant
  import av_arb_pkg::*;
#(
  parameter int MST_NUM = 2
) (
  input  logic [MST_NUM-1:0] req_i,
  input  logic [IDX_W-1:0]   ptr_i,
  output logic [MST_NUM-1:0] grant_o,
  output logic [IDX_W-1:0]   idx_o,
  output logic               valid_o
);
  localparam int EXT = 1 << IDX_W;

  logic [EXT-1:0]   req_ext_s;
  logic [EXT-1:0]   grant_ext_s;
  logic [IDX_W-1:0] cand_s;

  // Walk MST_NUM candidates from the pointer and keep the first requester.
  always_comb begin
    req_ext_s              = '0;
    req_ext_s[MST_NUM-1:0] = req_i;
    grant_ext_s            = '0;
    idx_o                  = '0;
    valid_o                = 1'b0;
    cand_s                 = ptr_i;
    for (int i = 0; i < MST_NUM; i++) begin
      if (!valid_o && req_ext_s[cand_s]) begin
        valid_o             = 1'b1;
        idx_o               = cand_s;
        grant_ext_s[cand_s] = 1'b1;
      end else begin
        valid_o = valid_o;
      end
      cand_s = wrap_inc(cand_s, MST_NUM);
    end
    grant_o = grant_ext_s[MST_NUM-1:0];
  end

endmodule

// File: rtl/av_rr_arbiter.sv
// Round-robin arbiter sharing one Avalon-MM slave among MST_NUM masters,
// one transaction at a time with a fixed slave read latency.
module av_rr_arbiter
  import av_arb_pkg::*;
#(
  parameter int DW      = 32,
  parameter int AW      = 16,
  parameter int MST_NUM = 2,
  parameter int RD_LAT  = 1
) (
  input  logic               clk_i,
  input  logic               reset_i,
  av_rr_arbiter_if.master    bus,
  output logic [MST_NUM-1:0] grant_o,
  output logic               busy_o
);
  localparam int BW = DW / 8;

  arb_state_e         state_q, state_d;
  logic [IDX_W-1:0]   ptr_q, ptr_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [AW-1:0]      addr_q, addr_d;
  logic [BW-1:0]      be_q, be_d;
  logic [DW-1:0]      wdata_q, wdata_d;
  logic               rd_q, rd_d;
  logic               wr_q, wr_d;
  logic [DW-1:0]      rdata_q, rdata_d;
  logic [MST_NUM-1:0] wait_q, wait_d;
  logic [MST_NUM-1:0] grant_q, grant_d;
  logic               busy_q, busy_d;

  logic [MST_NUM-1:0] req_s;
  logic [MST_NUM-1:0] rr_grant_s;
  logic [IDX_W-1:0]   rr_idx_s;
  logic               rr_valid_s;
  logic [AW-1:0]      sel_addr_s;
  logic [BW-1:0]      sel_be_s;
  logic [DW-1:0]      sel_wdata_s;
  logic               sel_write_s;

  assign req_s = bus.m_read | bus.m_write;

  rr_grant #(.MST_NUM(MST_NUM)) u_rr_grant (
    .req_i   (req_s),
    .ptr_i   (ptr_q),
    .grant_o (rr_grant_s),
    .idx_o   (rr_idx_s),
    .valid_o (rr_valid_s)
  );

  // One-hot AND-OR mux of the winning master's command fields.
  always_comb begin
    sel_addr_s  = '0;
    sel_be_s    = '0;
    sel_wdata_s = '0;
    sel_write_s = 1'b0;
    for (int i = 0; i < MST_NUM; i++) begin
      sel_addr_s  = sel_addr_s  | ({AW{rr_grant_s[i]}} & bus.m_address[i]);
      sel_be_s    = sel_be_s    | ({BW{rr_grant_s[i]}} & bus.m_byteenable[i]);
      sel_wdata_s = sel_wdata_s | ({DW{rr_grant_s[i]}} & bus.m_writedata[i]);
      sel_write_s = sel_write_s | (rr_grant_s[i] & bus.m_write[i]);
    end
  end

  // Next-state and registered-output logic; the completion pulse is loaded on
  // the edge that leaves CMD (write) or enters DONE (read).
  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    cnt_d   = cnt_q;
    addr_d  = addr_q;
    be_d    = be_q;
    wdata_d = wdata_q;
    rd_d    = 1'b0;
    wr_d    = 1'b0;
    rdata_d = rdata_q;
    wait_d  = '1;
    grant_d = grant_q;
    busy_d  = busy_q;
    case (state_q)
      IDLE: begin
        if (rr_valid_s) begin
          state_d = CMD;
          ptr_d   = wrap_inc(rr_idx_s, MST_NUM);
          addr_d  = sel_addr_s;
          be_d    = sel_be_s;
          wdata_d = sel_wdata_s;
          wr_d    = sel_write_s;
          rd_d    = ~sel_write_s;
          grant_d = rr_grant_s;
          busy_d  = 1'b1;
        end else begin
          state_d = IDLE;
        end
      end
      CMD: begin
        if (wr_q) begin
          state_d = IDLE;
          wait_d  = ~grant_q;
          grant_d = '0;
          busy_d  = 1'b0;
        end else begin
          state_d = RDWAIT;
          cnt_d   = '0;
        end
      end
      RDWAIT: begin
        if (cnt_q == CNT_W'(RD_LAT - 1)) begin
          state_d = DONE;
          rdata_d = bus.avms_readdata;
          wait_d  = ~grant_q;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      DONE: begin
        state_d = IDLE;
        grant_d = '0;
        busy_d  = 1'b0;
      end
      default: begin
        state_d = IDLE;
        grant_d = '0;
        busy_d  = 1'b0;
      end
    endcase
  end

  // State and output registers with asynchronous reset.
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state_q <= IDLE;
      ptr_q   <= '0;
      cnt_q   <= '0;
      addr_q  <= '0;
      be_q    <= '0;
      wdata_q <= '0;
      rd_q    <= 1'b0;
      wr_q    <= 1'b0;
      rdata_q <= '0;
      wait_q  <= '1;
      grant_q <= '0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
      be_q    <= be_d;
      wdata_q <= wdata_d;
      rd_q    <= rd_d;
      wr_q    <= wr_d;
      rdata_q <= rdata_d;
      wait_q  <= wait_d;
      grant_q <= grant_d;
      busy_q  <= busy_d;
    end
  end

  assign bus.avms_address    = addr_q;
  assign bus.avms_byteenable = be_q;
  assign bus.avms_writedata  = wdata_q;
  assign bus.avms_read       = rd_q;
  assign bus.avms_write      = wr_q;
  assign bus.m_readdata      = rdata_q;
  assign bus.m_waitrequest   = wait_q;
  assign grant_o             = grant_q;
  assign busy_o              = busy_q;

endmodule
